// File: rtl/rot_param_pkg.sv
// rot_param_pkg: shared constants and FSM state type for the rotary parameter editor.
package rot_param_pkg;
  localparam int NUM_PARAMS  = 4;
  localparam int IDX_W       = $clog2(NUM_PARAMS);
  localparam int VAL_W       = 8;
  localparam int MAX_VAL     = 255;
  localparam int STEP        = 4;
  localparam int DEFAULT_VAL = 128;
  localparam int PEND_MAX    = 7;
  localparam int PEND_W      = $clog2(PEND_MAX + 1) + 1;
  typedef enum logic [1:0] {IDLE, APPLY, WRITE} state_t;
endpackage

// File: rtl/rot_param_ctrl_sat_step.sv
// sat_step: one detent of change, clamped to 0..MAX_VAL.
module sat_step
  import rot_param_pkg::*;
(
  input  logic [VAL_W-1:0] i_val,
  input  logic             i_dn,
  output logic [VAL_W-1:0] o_val
);
  localparam logic [VAL_W-1:0] MAXV = VAL_W'(MAX_VAL);
  localparam logic [VAL_W-1:0] STP  = VAL_W'(STEP);
  assign o_val = i_dn ? (i_val < STP ? '0 : i_val - STP)
                      : (i_val > MAXV - STP ? MAXV : i_val + STP);
endmodule

// File: rtl/rot_param_ctrl.sv
// rot_param_ctrl: rotary/button parameter editor with req/ack write-back of every change.
module rot_param_ctrl
  import rot_param_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       rlrot,
  input  logic             btn_press,
  output logic [IDX_W-1:0] sel_idx,
  output logic [VAL_W-1:0] sel_val,
  output logic             wr_req,
  output logic [IDX_W-1:0] wr_addr,
  output logic [VAL_W-1:0] wr_data,
  input  logic             wr_ack,
  output logic             busy
);
  localparam logic signed [PEND_W:0] ONE = (PEND_W+1)'(1);
  localparam logic signed [PEND_W:0] LIM = (PEND_W+1)'(PEND_MAX);
  state_t                   r_state, w_state_nx;
  logic signed [PEND_W-1:0] r_pend, w_pend_nx;
  logic signed [PEND_W:0]   w_delta, w_cons, w_sum, w_sat;
  logic [VAL_W-1:0]         r_bank [NUM_PARAMS];
  logic [IDX_W-1:0]         r_sel_idx, r_wr_addr, w_sel_inc;
  logic [VAL_W-1:0]         r_sel_val, r_wr_data, w_new;
  logic                     r_btn_pend, r_wr_req, w_ev, w_step, w_sel_go;

  assign w_ev      = rlrot[1];
  assign w_delta   = !w_ev ? '0 : rlrot[0] ? -ONE : ONE;
  assign w_step    = r_state == APPLY && r_pend != '0;
  assign w_cons    = !w_step ? '0 : r_pend[PEND_W-1] ? ONE : -ONE;
  assign w_sum     = (PEND_W+1)'(r_pend) + w_delta + w_cons;
  assign w_sat     = w_sum > LIM ? LIM : w_sum < -LIM ? -LIM : w_sum;
  assign w_pend_nx = w_sat[PEND_W-1:0];
  // a press only moves the selection when nothing is queued; otherwise it waits in r_btn_pend
  assign w_sel_go  = r_state == IDLE && r_pend == '0 && !w_ev && (btn_press || r_btn_pend);
  assign w_sel_inc = r_sel_idx + 1'b1;

  sat_step u_step (.i_val(r_sel_val), .i_dn(r_pend[PEND_W-1]), .o_val(w_new));

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    w_state_nx = (r_pend != '0 || w_ev) ? APPLY : IDLE;
      APPLY:   w_state_nx = (r_pend == '0 && !w_ev) ? WRITE : APPLY;
      WRITE:   w_state_nx = !wr_ack ? WRITE : (w_pend_nx != '0 ? APPLY : IDLE);
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_btn_pend <= 1'b0;
      r_sel_idx  <= '0;
      r_sel_val  <= VAL_W'(DEFAULT_VAL);
      r_wr_req   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      for (int i = 0; i < NUM_PARAMS; i++) r_bank[i] <= VAL_W'(DEFAULT_VAL);
    end else begin
      r_state    <= w_state_nx;
      r_pend     <= w_pend_nx;
      r_btn_pend <= w_sel_go ? 1'b0 : (btn_press | r_btn_pend);
      if (w_sel_go) begin
        r_sel_idx <= w_sel_inc;
        r_sel_val <= r_bank[w_sel_inc];
      end
      if (w_step) begin
        r_sel_val         <= w_new;
        r_bank[r_sel_idx] <= w_new;
      end
      if (r_state == APPLY && w_state_nx == WRITE) begin
        r_wr_req  <= 1'b1;
        r_wr_addr <= r_sel_idx;
        r_wr_data <= r_sel_val;
      end else if (r_state == WRITE && wr_ack) begin
        r_wr_req  <= 1'b0;
      end
    end
  end

  assign sel_idx = r_sel_idx;
  assign sel_val = r_sel_val;
  assign wr_req  = r_wr_req;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = r_state != IDLE;
endmodule
